// File: rtl/packed_word_serializer.sv
// Splits a packed word into LSB-first BEAT_W beats. Beat 0 is valid 1 cycle after accept.
// A stalled beat holds all outputs. A new word is accepted only in IDLE or on the last-beat handshake.
module packed_word_serializer #(
    parameter  int IN_W   = 126,
    parameter  int BEAT_W = 32,
    localparam int NBEATS = (IN_W + BEAT_W - 1) / BEAT_W,
    localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last,
    output logic [IDX_W-1:0]  out_idx
);

    localparam int SH_W = NBEATS * BEAT_W;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q;
    logic [SH_W-1:0]   sh_q;
    logic [BEAT_W-1:0] out_data_q;
    logic [IDX_W-1:0]  out_idx_q;
    logic              out_valid_q;
    logic              out_last_q;

    logic [SH_W-1:0]   in_ext;
    logic [IDX_W-1:0]  idx_nxt;
    logic              beat_xfer;
    logic              accept;

    // Padding above IN_W is forced to zero so the last beat is clean.
    always_comb begin
        in_ext             = '0;
        in_ext[IN_W-1:0]   = in_data;
        idx_nxt            = out_idx_q + IDX_ONE;
    end

    assign beat_xfer = out_valid_q && out_ready;
    assign in_ready  = !reset && ((state_q == IDLE) || (beat_xfer && out_last_q));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (accept) begin
            // sh_q keeps only the beats not yet presented on out_data.
            state_q     <= SEND;
            sh_q        <= in_ext >> BEAT_W;
            out_data_q  <= in_ext[BEAT_W-1:0];
            out_idx_q   <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= (NBEATS == 1);
        end else if (beat_xfer) begin
            if (out_last_q) begin
                state_q     <= IDLE;
                out_idx_q   <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                sh_q        <= sh_q >> BEAT_W;
                out_data_q  <= sh_q[BEAT_W-1:0];
                out_idx_q   <= idx_nxt;
                out_last_q  <= (idx_nxt == LAST_IDX);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_packed_word_serializer.sv
// Scoreboard bench for packed_word_serializer: a driver queues expected beats, a negedge monitor checks them.
module tb_packed_word_serializer;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [125:0] in_data = '0;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [1:0]   out_idx;

    logic man_rdy  = 1'b1;
    logic rnd_rdy  = 1'b1;
    logic rand_mode = 1'b0;
    assign out_ready = rand_mode ? rnd_rdy : man_rdy;

    packed_word_serializer dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .out_idx  (out_idx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1 rnd_rdy = ($urandom_range(0, 1) == 1);
    end

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  idx;
        logic        last;
    } beat_t;

    beat_t        sb[$];
    logic [125:0] wq[$];
    int           n_chk = 0;
    int           n_fail = 0;
    time          t_acc = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every handshaken beat against the queue and rebuilds whole words.
    logic [127:0] acc = '0;
    logic         prev_stall = 1'b0;
    logic         lat_pend = 1'b0;
    logic [31:0]  sv_dat = '0;
    logic [1:0]   sv_idx = '0;
    logic         sv_last = 1'b0;

    always @(negedge clock) begin
        beat_t b;
        if (reset) begin
            prev_stall = 1'b0;
            lat_pend   = 1'b0;
            acc        = '0;
        end else begin
            chk("in_ready_rule", 128'(in_ready), 128'(!out_valid || (out_ready && out_last)));
            if (prev_stall) begin
                chk("stall_valid", 128'(out_valid), 128'(1));
                chk("stall_data", 128'(out_data), 128'(sv_dat));
                chk("stall_idx", 128'(out_idx), 128'(sv_idx));
                chk("stall_last", 128'(out_last), 128'(sv_last));
            end
            if (lat_pend) begin
                chk("latency_valid", 128'(out_valid), 128'(1));
                chk("latency_idx0", 128'(out_idx), 128'(0));
            end
            lat_pend = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h idx %0d, required no beat", out_data, out_idx);
                end else begin
                    b = sb.pop_front();
                    chk("beat_data", 128'(out_data), 128'(b.dat));
                    chk("beat_idx", 128'(out_idx), 128'(b.idx));
                    chk("beat_last", 128'(out_last), 128'(b.last));
                end
                acc[32*out_idx +: 32] = out_data;
                if (out_last) begin
                    if (wq.size() != 0) chk("word_rebuild", 128'(acc[125:0]), 128'(wq.pop_front()));
                    acc = '0;
                end
            end
            prev_stall = out_valid && !out_ready;
            sv_dat  = out_data;
            sv_idx  = out_idx;
            sv_last = out_last;
        end
    end

    task automatic send_word(input logic [125:0] w, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready 0 for 200 cycles, required 1");
            in_valid = 1'b0;
            return;
        end
        sb.push_back(beat_t'{dat: e0, idx: 2'd0, last: 1'b0});
        sb.push_back(beat_t'{dat: e1, idx: 2'd1, last: 1'b0});
        sb.push_back(beat_t'{dat: e2, idx: 2'd2, last: 1'b0});
        sb.push_back(beat_t'{dat: e3, idx: 2'd3, last: 1'b1});
        wq.push_back(w);
        t_acc = $time;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = ~w;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clock);
        chk("drain_empty", 128'(sb.size()), 128'(0));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        time          ta;
        logic [127:0] r;
        logic [127:0] ext;
        bit           hit;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_valid", 128'(out_valid), 128'(0));
        chk("reset_last", 128'(out_last), 128'(0));
        chk("reset_idx", 128'(out_idx), 128'(0));
        chk("reset_data", 128'(out_data), 128'(0));
        chk("reset_in_ready", 128'(in_ready), 128'(0));
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("release_in_ready", 128'(in_ready), 128'(1));
        repeat (20) begin
            @(negedge clock);
            chk("idle_valid", 128'(out_valid), 128'(0));
            chk("idle_in_ready", 128'(in_ready), 128'(1));
        end
        @(posedge clock);
        #1;

        send_word(126'h2A_DEADBEEF_CAFEBABE_01234567,
                  32'h01234567, 32'hCAFEBABE, 32'hDEADBEEF, 32'h0000002A);
        wait_drain();

        send_word({126{1'b1}}, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3FFFFFFF);
        wait_drain();

        send_word(126'h11_22223333_44445555_66667777,
                  32'h66667777, 32'h44445555, 32'h22223333, 32'h00000011);
        ta = t_acc;
        send_word(126'h3F_89ABCDEF_FEDCBA98_76543210,
                  32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h0000003F);
        chk("b2b_accept_spacing", 128'(t_acc - ta), 128'(40));
        wait_drain();

        rand_mode = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            r   = {$urandom, $urandom, $urandom, $urandom};
            ext = {2'b00, r[125:0]};
            send_word(r[125:0], ext[31:0], ext[63:32], ext[95:64], ext[127:96]);
        end
        wait_drain();
        rand_mode = 1'b0;
        man_rdy   = 1'b1;

        send_word(126'h05_0BADF00D_13579BDF_2468ACE0,
                  32'h2468ACE0, 32'h13579BDF, 32'h0BADF00D, 32'h00000005);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (out_valid && out_idx == 2'd2) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_beat2", 128'(hit), 128'(1));
        man_rdy = 1'b0;
        reset   = 1'b1;
        @(negedge clock);
        chk("midreset_in_ready", 128'(in_ready), 128'(0));
        @(posedge clock);
        #1;
        sb.delete();
        wq.delete();
        @(negedge clock);
        chk("midreset_valid", 128'(out_valid), 128'(0));
        chk("midreset_idx", 128'(out_idx), 128'(0));
        chk("midreset_data", 128'(out_data), 128'(0));
        chk("midreset_in_ready2", 128'(in_ready), 128'(0));
        @(posedge clock);
        #1;
        reset   = 1'b0;
        man_rdy = 1'b1;
        @(negedge clock);
        chk("postreset_in_ready", 128'(in_ready), 128'(1));
        chk("postreset_valid", 128'(out_valid), 128'(0));
        @(posedge clock);
        #1;
        send_word(126'h00_AAAA5555_0F0F0F0F_C3C3C3C3,
                  32'hC3C3C3C3, 32'h0F0F0F0F, 32'hAAAA5555, 32'h00000000);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/packed_word_serializer.md
# packed_word_serializer

Downstream consumer of the grouped bundle flattener: takes the 126-bit packed word (`{in_11_8, in_7_4, in_3_0}` layout, LSB = `in_b_0`) with a valid/ready handshake and emits it as a sequence of narrower beats, LSB-first, over a registered valid/ready output. It is the width adapter between the flattened bundle vector and the 32-bit link.

## Interface

- `IN_W`, default 126: packed input word width.
- `BEAT_W`, default 32: output beat width.
- `NBEATS`, derived, ceil(IN_W/BEAT_W) = 4: beats per word. Not overridable.

- `clock` input 1: single clock; all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: packed word present.
- `in_ready` output 1: block accepts the word this cycle.
- `in_data` input IN_W: packed word.
- `out_valid` output 1: beat present (registered).
- `out_ready` input 1: downstream accepts beat.
- `out_data` output BEAT_W: current beat (registered).
- `out_last` output 1: current beat is beat NBEATS-1 (registered).
- `out_idx` output clog2(NBEATS) = 2: index of current beat (registered).

## Operation

- States: IDLE (no word held), SEND (word held, beats being emitted).
- Word accept: `in_valid && in_ready`. Captures `in_data`, zero-extended to NBEATS*BEAT_W = 128 bits, into a shift register. Loads beat 0 (bits 31:0) into `out_data`, `out_idx` = 0, `out_valid` = 1, `out_last` = (NBEATS == 1). Enters SEND.
- Beat transfer: `out_valid && out_ready`.
  - Not last: shift register shifts right by BEAT_W, `out_data` takes the next beat, `out_idx` increments, and `out_last` is set when `out_idx` becomes NBEATS-1.
  - Last: if a word is accepted in the same cycle, that word's beat 0 loads immediately (back-to-back, no bubble). Otherwise `out_valid` = 0, `out_last` = 0, `out_idx` = 0, `out_data` holds its value, and the state goes to IDLE.
- `in_ready` (combinational) = !reset && (IDLE || (out_valid && out_ready && out_last)).
- Beat k = packed bits [32k+31 : 32k]. Beat 3 = {2'b00, in_data[125:96]}. Padding bits are always zero.
- Stall: while `out_valid && !out_ready`, `out_data`, `out_idx`, `out_last` and `out_valid` hold stable. `in_data` changes are ignored.
- `in_data` is sampled only on accept. It does not need to be held afterwards.
- Reset in the middle of a word drops the word. No partial beats are emitted after reset.

## Timing

- Reset values: `out_valid` = 0, `out_last` = 0, `out_idx` = 0, `out_data` = 0, state IDLE, shift register = 0. `in_ready` = 0 while `reset` is high, and 1 in the first cycle after release.
- Latency: word accepted in cycle N gives beat 0 valid in cycle N+1.
- Throughput with `out_ready` held high: one word per NBEATS cycles. Beats are contiguous and consecutive words have no gap.
- No combinational path from `in_valid`/`in_data` to any output. `in_ready` depends combinationally on `out_ready` (last-beat overlap only).

## Test plan

- Reset release, then `in_data` = 126'h2A_DEADBEEF_CAFEBABE_01234567 accepted with `out_ready` = 1:
  - beats are 0x01234567, 0xCAFEBABE, 0xDEADBEEF, 0x0000002A in cycles N+1..N+4;
  - `out_idx` is 0..3;
  - `out_last` is high only on 0x0000002A.
- All-ones input: beats 0–2 = 0xFFFFFFFF, beat 3 = 0x3FFFFFFF, which checks the zero padding.
- Two words offered back-to-back, `out_ready` = 1:
  - second word accepted in the same cycle as the first word's last beat;
  - second word's beat 0 appears the next cycle;
  - `out_valid` has no low cycle across 8 beats.
- `out_ready` toggled randomly, 50%:
  - beats hold stable while stalled;
  - `in_ready` = 0 except on the last-beat handshake or in IDLE;
  - the reconstructed 126-bit word matches the input for 1000 random words.
- `reset` asserted during beat 2 of a word:
  - next cycle `out_valid` = 0, `out_idx` = 0, `out_data` = 0;
  - `in_ready` is low while reset is high and high after release;
  - the next word starts at beat 0.
- `in_valid` = 0 for 20 cycles after reset: `out_valid` stays 0 and `in_ready` stays 1.
